sap_control_sequencer: RTL

Microcoded control unit for the 8-bit SAP datapath. It steps a T-state counter on every clock and decodes the current T-state, IR opcode and flags into the per-register write/enable strobes. Those strobes are the `write` and `enable` inputs of every d_storage_register on the shared bus (PC, MAR, RAM, IR, A, B, ALU, OUT). It sits directly upstream of those registers and guarantees at most one bus driver per step.

---
 rtl/sap_control_sequencer_if.sv | 38 +++
 rtl/sap_control_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the SAP sequencer and the bus registers it strobes.
// The master is the sequencer; the slave is the datapath/bench side.
interface sap_control_sequencer_if;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic [2:0] tstate;
  logic       pc_out;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_write;
  logic       ram_out;
  logic       ram_write;
  logic       ir_write;
  logic       ir_out;
  logic       a_write;
  logic       a_out;
  logic       b_write;
  logic       alu_out;
  logic       alu_sub;
  logic       flags_write;
  logic       out_write;
  logic       halt;

  modport master (
    input  opcode, carry_flag, zero_flag,
    output tstate, pc_out, pc_inc, pc_load, mar_write, ram_out, ram_write,
           ir_write, ir_out, a_write, a_out, b_write, alu_out, alu_sub,
           flags_write, out_write, halt
  );

  modport slave (
    output opcode, carry_flag, zero_flag,
    input  tstate, pc_out, pc_inc, pc_load, mar_write, ram_out, ram_write,
           ir_write, ir_out, a_write, a_out, b_write, alu_out, alu_sub,
           flags_write, out_write, halt
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP microcoded control unit: T-state counter plus opcode/flag decode to bus strobes.
// Optional macro EARLY_RETIRE_EN returns to T0 right after an instruction's last busy step.
module sap_control_sequencer #(
  parameter int NUM_TSTATES = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sap_control_sequencer_if.master       bus
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic pc_out, pc_inc, pc_load, mar_write, ram_out, ram_write, ir_write, ir_out;
    logic a_write, a_out, b_write, alu_out, alu_sub, flags_write, out_write, halt;
  } ctrl_t;

  localparam logic [2:0] T_LAST = 3'(NUM_TSTATES - 1);

  opcode_e    op;
  logic [2:0] tstate_q, tstate_d;
  logic       halted_q, halted_d;
  ctrl_t      ctrl;

  assign op = opcode_e'(bus.opcode);

  // NOTE: reset is sampled on the clock edge, and state uses <= so every flop
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tstate_q <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

`ifdef EARLY_RETIRE_EN
  logic [2:0] retire_t;

  always_comb begin
    unique case (op)
      OP_LDA, OP_STA: retire_t = 3'd3;
      OP_ADD, OP_SUB: retire_t = 3'd4;
      default:        retire_t = 3'd2;
    endcase
  end
`endif

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    halted_d = halted_q;
    tstate_d = (tstate_q == T_LAST) ? 3'd0 : tstate_q + 3'd1;
`ifdef EARLY_RETIRE_EN
    if (tstate_q == retire_t) tstate_d = 3'd0;
`endif
    if (halted_q) begin
      tstate_d = tstate_q;
    end else if (tstate_q == 3'd2 && op == OP_HLT) begin
      halted_d = 1'b1;
      tstate_d = 3'd2;
    end
  end

  always_comb begin
    ctrl = '0;
    case (tstate_q)
      3'd0: begin ctrl.pc_out = 1'b1; ctrl.mar_write = 1'b1; end
      3'd1: begin ctrl.ram_out = 1'b1; ctrl.ir_write = 1'b1; ctrl.pc_inc = 1'b1; end
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctrl.ir_out = 1'b1; ctrl.mar_write = 1'b1; end
          OP_LDI: begin ctrl.ir_out = 1'b1; ctrl.a_write = 1'b1; end
          OP_JMP: begin ctrl.ir_out = 1'b1; ctrl.pc_load = 1'b1; end
          OP_JC:  begin ctrl.ir_out = bus.carry_flag; ctrl.pc_load = bus.carry_flag; end
          OP_JZ:  begin ctrl.ir_out = bus.zero_flag;  ctrl.pc_load = bus.zero_flag;  end
          OP_OUT: begin ctrl.a_out = 1'b1; ctrl.out_write = 1'b1; end
          OP_HLT: ctrl.halt = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA:         begin ctrl.ram_out = 1'b1; ctrl.a_write = 1'b1; end
          OP_ADD, OP_SUB: begin ctrl.ram_out = 1'b1; ctrl.b_write = 1'b1; end
          OP_STA:         begin ctrl.a_out = 1'b1; ctrl.ram_write = 1'b1; end
          default: ;
        endcase
      end
      3'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ctrl.alu_out     = 1'b1;
          ctrl.a_write     = 1'b1;
          ctrl.flags_write = 1'b1;
          ctrl.alu_sub     = (op == OP_SUB);
        end
      end
      default: ;
    endcase
    // Reset wins over everything, then a halted machine only asserts halt.
    if (!rst_n) begin
      ctrl = '0;
    end else if (halted_q) begin
      ctrl      = '0;
      ctrl.halt = 1'b1;
    end
  end

  assign bus.tstate      = tstate_q;
  assign bus.pc_out      = ctrl.pc_out;
  assign bus.pc_inc      = ctrl.pc_inc;
  assign bus.pc_load     = ctrl.pc_load;
  assign bus.mar_write   = ctrl.mar_write;
  assign bus.ram_out     = ctrl.ram_out;
  assign bus.ram_write   = ctrl.ram_write;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.ir_out      = ctrl.ir_out;
  assign bus.a_write     = ctrl.a_write;
  assign bus.a_out       = ctrl.a_out;
  assign bus.b_write     = ctrl.b_write;
  assign bus.alu_out     = ctrl.alu_out;
  assign bus.alu_sub     = ctrl.alu_sub;
  assign bus.flags_write = ctrl.flags_write;
  assign bus.out_write   = ctrl.out_write;
  assign bus.halt        = ctrl.halt;

endmodule
